// File: rtl/dec_instr_queue.sv
// -----------------------------------------------------------------------------
// dec_instr_queue
//   Multi-lane instruction queue between fetch and decode/rename. It is a
//   circular buffer of DEPTH entries of WIDTH bits, with 1 or 2 lanes per cycle
//   on each side.
//
//   Parameters:
//     DEPTH  number of entries (power of 2, >= 2*LANES)
//     WIDTH  payload bits per entry
//     LANES  enqueue/dequeue lanes per cycle (1 or 2)
//
//   Ports:
//     CLK        rising-edge clock
//     RESET      asynchronous, active-high reset (clears pointers and storage)
//     FLUSH      synchronous flush; discards the queue and this cycle's traffic
//     enq_valid  per-lane enqueue request (lane 1 only counts with lane 0)
//     enq_data   lane i payload at [i*WIDTH +: WIDTH]
//     enq_ready  all-ones when at least LANES entries are free (registered)
//     deq_valid  lane i holds the i-th oldest entry
//     deq_data   lane i payload (oldest in lane 0)
//     deq_ready  per-lane consume (lane 1 only counts with lane 0)
//     count      current occupancy (registered)
//     empty      count == 0 (registered)
//     full       count == DEPTH (registered)
//     halt       ~enq_ready[0]; fetch freeze (registered)
//
//   Optional feature:
//     DEC_QUEUE_BYPASS_EN  when defined, an empty queue forwards accepted
//                          enqueue lanes straight to deq in the same cycle.
//                          Lanes consumed that way are not written to storage.
// -----------------------------------------------------------------------------
module dec_instr_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LANES = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         FLUSH,
  input  logic [LANES-1:0]             enq_valid,
  input  logic [LANES*WIDTH-1:0]       enq_data,
  output logic [LANES-1:0]             enq_ready,
  output logic [LANES-1:0]             deq_valid,
  output logic [LANES*WIDTH-1:0]       deq_data,
  input  logic [LANES-1:0]             deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         halt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Highest occupancy that still leaves room for a full group of LANES entries.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - LANES);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    n_enq;
  logic [CW-1:0]    n_deq;
  logic [CW-1:0]    n_skip;
  logic [CW-1:0]    cnt_next;
  logic             ready_next;

`ifdef DEC_QUEUE_BYPASS_EN
  logic             bypass;
  // Forwarding is suppressed during reset so outputs read as an empty queue.
  assign bypass = (count == '0) && !FLUSH && !RESET;
`endif

  // Accepted enqueue lanes: leading run of enq_valid, gated by registered ready.
  always_comb begin
    logic run;
    n_enq = '0;
    run   = enq_ready[0];
    for (int i = 0; i < LANES; i++) begin
      run = run & enq_valid[i];
      if (run) n_enq = n_enq + CW'(1);
    end
  end

  // Dequeue view: stored entries, or the incoming lanes when bypassing.
  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      deq_valid[i]                = (count > CW'(i));
      deq_data[i*WIDTH +: WIDTH]  = mem[AW'(rd_ptr + PW'(i))];
    end
`ifdef DEC_QUEUE_BYPASS_EN
    if (bypass) begin
      for (int i = 0; i < LANES; i++) begin
        deq_valid[i] = (CW'(i) < n_enq);
      end
      deq_data = enq_data;
    end
`endif
  end

  // Consumed lanes: leading run of deq_valid & deq_ready.
  always_comb begin
    logic run;
    n_deq = '0;
    run   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      run = run & deq_valid[i] & deq_ready[i];
      if (run) n_deq = n_deq + CW'(1);
    end
  end

  // Lanes already handed to the consumer through the bypass are not stored.
  always_comb begin
    n_skip = '0;
`ifdef DEC_QUEUE_BYPASS_EN
    if (bypass) n_skip = n_deq;
`endif
  end

  // Next occupancy and the registered ready/status flags derived from it.
  always_comb begin
    cnt_next = count + n_enq - n_deq;
    if (FLUSH) cnt_next = '0;
    ready_next = (cnt_next <= READY_MAX);
  end

  // Pointers, storage and registered status.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      enq_ready <= '1;
      halt      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count     <= cnt_next;
      empty     <= (cnt_next == '0);
      full      <= (cnt_next == CW'(DEPTH));
      enq_ready <= {LANES{ready_next}};
      halt      <= !ready_next;
      if (FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if ((CW'(i) < n_enq) && (CW'(i) >= n_skip)) begin
            mem[AW'(wr_ptr + PW'(i))] <= enq_data[i*WIDTH +: WIDTH];
          end
        end
        wr_ptr <= wr_ptr + PW'(n_enq);
        rd_ptr <= rd_ptr + PW'(n_deq);
      end
    end
  end

endmodule
